// File: rtl/ll_scheduler.sv
// Round-robin push/pop scheduler sharing one linked_list among NUM_LISTS requesters.
// Define LL_SCHED_QUOTA_EN to cap each list at QUOTA entries.
module ll_scheduler #(
    parameter int NUM_ELEMS = 4,
    parameter int NUM_LISTS = 2,
    parameter int QUOTA     = 2,
    parameter int SEL_WIDTH = $clog2(NUM_LISTS),
    parameter int CNT_WIDTH = $clog2(NUM_ELEMS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LISTS-1:0] push_req,
    input  logic [NUM_LISTS-1:0] pop_req,
    output logic [NUM_LISTS-1:0] push_gnt,
    output logic [NUM_LISTS-1:0] pop_gnt,
    output logic                 push,
    output logic                 pop,
    output logic [SEL_WIDTH-1:0] push_sel,
    output logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 full,
    output logic [NUM_LISTS-1:0] empty
);

    if (NUM_LISTS < 2 || NUM_LISTS > NUM_ELEMS) begin : g_bad_lists
        $error("ll_scheduler: NUM_LISTS must be in 2..NUM_ELEMS");
    end
    if (QUOTA < 1 || QUOTA > NUM_ELEMS) begin : g_bad_quota
        $error("ll_scheduler: QUOTA must be in 1..NUM_ELEMS");
    end

    logic [CNT_WIDTH-1:0] count [NUM_LISTS];
    logic [CNT_WIDTH-1:0] total_count;
    logic [SEL_WIDTH-1:0] push_ptr;
    logic [SEL_WIDTH-1:0] pop_ptr;
    logic [NUM_LISTS-1:0] push_elig;
    logic [NUM_LISTS-1:0] pop_elig;
    logic [NUM_LISTS-1:0] push_win;
    logic [NUM_LISTS-1:0] pop_win;
    logic [SEL_WIDTH-1:0] push_idx;
    logic [SEL_WIDTH-1:0] pop_idx;
    logic                 mem_full;

    // First eligible index at or after ptr, wrapping mod NUM_LISTS.
    function automatic logic [NUM_LISTS-1:0] rr_pick(
        input logic [NUM_LISTS-1:0] elig,
        input logic [SEL_WIDTH-1:0] ptr
    );
        logic [NUM_LISTS-1:0] win;
        int idx;
        win = '0;
        idx = 0;
        for (int i = 0; i < NUM_LISTS; i++) begin
            idx = (int'(ptr) + i) % NUM_LISTS;
            if (win == '0 && elig[idx]) win[idx] = 1'b1;
        end
        return win;
    endfunction

    function automatic logic [SEL_WIDTH-1:0] enc(input logic [NUM_LISTS-1:0] win);
        logic [SEL_WIDTH-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_LISTS; i++) begin
            if (win[i]) sel = SEL_WIDTH'(i);
        end
        return sel;
    endfunction

    function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] idx);
        return SEL_WIDTH'((int'(idx) + 1) % NUM_LISTS);
    endfunction

    assign mem_full = (total_count == CNT_WIDTH'(NUM_ELEMS));

    always_comb begin
        push_elig = '0;
        pop_elig  = '0;
        for (int k = 0; k < NUM_LISTS; k++) begin
            pop_elig[k]  = pop_req[k] && (count[k] != '0);
            push_elig[k] = push_req[k] && !mem_full;
`ifdef LL_SCHED_QUOTA_EN
            if (count[k] >= CNT_WIDTH'(QUOTA)) push_elig[k] = 1'b0;
`endif
        end
    end

    assign push_win = rr_pick(push_elig, push_ptr);
    assign pop_win  = rr_pick(pop_elig, pop_ptr);
    assign push_idx = enc(push_win);
    assign pop_idx  = enc(pop_win);

    // Grants are squashed during reset so the list sees nothing in flight.
    assign push_gnt = rst ? '0 : push_win;
    assign pop_gnt  = rst ? '0 : pop_win;
    assign push     = |push_gnt;
    assign pop      = |pop_gnt;
    assign push_sel = rst ? '0 : push_idx;
    assign pop_sel  = rst ? '0 : pop_idx;
    assign full     = mem_full;

    always_comb begin
        empty = '0;
        for (int k = 0; k < NUM_LISTS; k++) begin
            empty[k] = (count[k] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_count <= '0;
            push_ptr    <= '0;
            pop_ptr     <= '0;
            for (int k = 0; k < NUM_LISTS; k++) begin
                count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_LISTS; k++) begin
                count[k] <= count[k] + CNT_WIDTH'(push_win[k])
                                     - CNT_WIDTH'(pop_win[k]);
            end
            total_count <= total_count + CNT_WIDTH'(|push_win)
                                       - CNT_WIDTH'(|pop_win);
            if (|push_win) push_ptr <= wrap_inc(push_idx);
            if (|pop_win)  pop_ptr  <= wrap_inc(pop_idx);
        end
    end

endmodule

// File: tb/tb_ll_scheduler.sv
// Scoreboard bench for ll_scheduler (NUM_ELEMS=4, NUM_LISTS=2, QUOTA=2).
// Quota scenario runs only when LL_SCHED_QUOTA_EN is defined.
module tb_ll_scheduler;

    localparam int NE = 4;
    localparam int NL = 2;
    localparam int Q  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] push_req, pop_req;
    logic [1:0] push_gnt, pop_gnt;
    logic       push, pop, push_sel, pop_sel, full;
    logic [1:0] empty;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] preq;
        logic [1:0] oreq;
        logic [1:0] pg;
        logic [1:0] og;
    } step_t;

    logic [7:0] sb [$];

    ll_scheduler #(.NUM_ELEMS(NE), .NUM_LISTS(NL), .QUOTA(Q)) dut (
        .clk(clk), .rst(rst),
        .push_req(push_req), .pop_req(pop_req),
        .push_gnt(push_gnt), .pop_gnt(pop_gnt),
        .push(push), .pop(pop),
        .push_sel(push_sel), .pop_sel(pop_sel),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Expected output bundle derived from the one-hot grants.
    function automatic logic [7:0] exp_of(input logic [1:0] pg, input logic [1:0] og);
        return {pg, og, |pg, |og, pg[1], og[1]};
    endfunction

    function automatic logic [7:0] obs();
        return {push_gnt, pop_gnt, push, pop, push_sel, pop_sel};
    endfunction

    // Called at a negedge: drive requests, queue the expectation, let it settle.
    task automatic drive(input step_t s);
        push_req = s.preq;
        pop_req  = s.oreq;
        sb.push_back(exp_of(s.pg, s.og));
        #2;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b1; push_req = 2'b11; pop_req = 2'b11;
        @(negedge clk); #1;
        n_tests++;
        if (obs() !== 8'h00) begin
            n_fail++; $display("FAIL rst_hold: got %b want %b", obs(), 8'h00);
        end
        @(negedge clk);
        rst = 1'b0; pop_req = 2'b00;
        #1;
        n_tests++;
        if ({full, empty} !== 3'b011) begin
            n_fail++; $display("FAIL rst_flags: got %b want %b", {full, empty}, 3'b011);
        end
        sb.push_back(exp_of(2'b01, 2'b00));
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++; $display("FAIL first_push: got %b want %b", obs(), e);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs() !== 8'h00) begin
            n_fail++; $display("FAIL async_drop: got %b want %b", obs(), 8'h00);
        end
        @(negedge clk);
        push_req = 2'b00;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({full, empty} !== 3'b011) begin
            n_fail++; $display("FAIL rst_discard: got %b want %b", {full, empty}, 3'b011);
        end
        @(negedge clk);
    endtask

    task automatic test_push_fairness();
        step_t st [5] = '{
            '{2'b11, 2'b00, 2'b01, 2'b00}, '{2'b11, 2'b00, 2'b10, 2'b00},
            '{2'b11, 2'b00, 2'b01, 2'b00}, '{2'b11, 2'b00, 2'b10, 2'b00},
            '{2'b11, 2'b00, 2'b00, 2'b00}};
        logic [7:0] e;
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL fair[%0d]: got %b want %b", i, obs(), e);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if ({full, empty} !== 3'b100) begin
            n_fail++; $display("FAIL fair_flags: got %b want %b", {full, empty}, 3'b100);
        end
    endtask

    task automatic test_full_boundary();
        step_t st [2] = '{
            '{2'b01, 2'b10, 2'b00, 2'b10}, '{2'b01, 2'b00, 2'b01, 2'b00}};
        logic [7:0] e;
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL full[%0d]: got %b want %b", i, obs(), e);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (full !== 1'b1) begin
            n_fail++; $display("FAIL full_again: got %b want 1", full);
        end
    endtask

    task automatic test_empty_masking();
        step_t drain [5] = '{
            '{2'b00, 2'b11, 2'b00, 2'b01}, '{2'b00, 2'b11, 2'b00, 2'b10},
            '{2'b00, 2'b11, 2'b00, 2'b01}, '{2'b00, 2'b11, 2'b00, 2'b01},
            '{2'b00, 2'b11, 2'b00, 2'b00}};
        step_t st [3] = '{
            '{2'b00, 2'b01, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b01, 2'b00},
            '{2'b00, 2'b01, 2'b00, 2'b01}};
        logic [1:0] exp_empty [3] = '{2'b11, 2'b10, 2'b11};
        logic [7:0] e;
        foreach (drain[i]) begin
            drive(drain[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL drain[%0d]: got %b want %b", i, obs(), e);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if ({full, empty} !== 3'b011) begin
            n_fail++; $display("FAIL drain_flags: got %b want %b", {full, empty}, 3'b011);
        end
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL mask[%0d]: got %b want %b", i, obs(), e);
            end
            @(negedge clk);
            #1;
            n_tests++;
            if (empty !== exp_empty[i]) begin
                n_fail++; $display("FAIL mask_empty[%0d]: got %b want %b", i, empty, exp_empty[i]);
            end
        end
    endtask

    task automatic test_same_list();
        step_t st [4] = '{
            '{2'b10, 2'b00, 2'b10, 2'b00}, '{2'b10, 2'b10, 2'b10, 2'b10},
            '{2'b00, 2'b11, 2'b00, 2'b10}, '{2'b00, 2'b10, 2'b00, 2'b00}};
        logic [1:0] exp_empty [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
        logic [7:0] e;
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL same[%0d]: got %b want %b", i, obs(), e);
            end
            @(negedge clk);
            #1;
            n_tests++;
            if (empty !== exp_empty[i]) begin
                n_fail++; $display("FAIL same_empty[%0d]: got %b want %b", i, empty, exp_empty[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st [5] = '{
            '{2'b11, 2'b00, 2'b01, 2'b00}, '{2'b11, 2'b11, 2'b10, 2'b01},
            '{2'b11, 2'b11, 2'b01, 2'b10}, '{2'b11, 2'b11, 2'b10, 2'b01},
            '{2'b00, 2'b11, 2'b00, 2'b10}};
        logic [7:0] e;
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL b2b[%0d]: got %b want %b", i, obs(), e);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if ({full, empty} !== 3'b011) begin
            n_fail++; $display("FAIL b2b_flags: got %b want %b", {full, empty}, 3'b011);
        end
    endtask

`ifdef LL_SCHED_QUOTA_EN
    task automatic test_quota();
        step_t st [6] = '{
            '{2'b01, 2'b00, 2'b01, 2'b00}, '{2'b01, 2'b00, 2'b01, 2'b00},
            '{2'b11, 2'b00, 2'b10, 2'b00}, '{2'b11, 2'b00, 2'b10, 2'b00},
            '{2'b00, 2'b01, 2'b00, 2'b01}, '{2'b01, 2'b00, 2'b01, 2'b00}};
        logic [7:0] e;
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL quota[%0d]: got %b want %b", i, obs(), e);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (full !== 1'b1) begin
            n_fail++; $display("FAIL quota_full: got %b want 1", full);
        end
    endtask
`endif

    task automatic test_random();
        int cnt [NL];
        int tot, pp, op;
        logic [1:0] pg, og, pr, orq;
        logic [2:0] ef;
        logic [7:0] e;
        rst = 1'b1; push_req = 2'b00; pop_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        cnt = '{0, 0}; tot = 0; pp = 0; op = 0;
        repeat (300) begin
            pr  = 2'($urandom_range(0, 3));
            orq = 2'($urandom_range(0, 3));
            pg = 2'b00; og = 2'b00;
            for (int i = 0; i < NL; i++) begin
                int k;
                bit ok;
                k = (pp + i) % NL;
                ok = pr[k] && tot < NE;
`ifdef LL_SCHED_QUOTA_EN
                ok = ok && cnt[k] < Q;
`endif
                if (pg == 2'b00 && ok) pg[k] = 1'b1;
                k = (op + i) % NL;
                if (og == 2'b00 && orq[k] && cnt[k] != 0) og[k] = 1'b1;
            end
            ef = {tot == NE, cnt[1] == 0, cnt[0] == 0};
            drive('{pr, orq, pg, og});
            n_tests++;
            if ({full, empty} !== ef) begin
                n_fail++; $display("FAIL rnd_flags: got %b want %b", {full, empty}, ef);
            end
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL rnd_gnt: req %b/%b got %b want %b", pr, orq, obs(), e);
            end
            for (int k = 0; k < NL; k++) begin
                cnt[k] = cnt[k] + int'(pg[k]) - int'(og[k]);
                if (pg[k]) pp = (k + 1) % NL;
                if (og[k]) op = (k + 1) % NL;
            end
            tot = tot + int'(|pg) - int'(|og);
            @(negedge clk);
        end
        push_req = 2'b00; pop_req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_push_fairness();
        test_full_boundary();
        test_empty_masking();
        test_same_list();
        test_back_to_back();
`ifdef LL_SCHED_QUOTA_EN
        test_quota();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
